aes_inv_sub_bytes_unit: RTL and testbench

Multi-cycle inverse SubBytes engine for the decryption path of the SIMD AES datapath. It is the inverse counterpart of the forward `aes_sbox` lookup. It accepts a 128-bit AES state over a valid/ready handshake and substitutes `LANES` bytes per cycle through parallel inverse S-box lookups. It returns the fully substituted state over a second valid/ready handshake, and sits between InvShiftRows and AddRoundKey in the decrypt round.

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_inv_sbox.sv | 12 +
 rtl/aes_inv_sub_bytes_unit.sv | 105 ++++++++++
 tb/tb_aes_inv_sub_bytes_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, sizes and the inverse S-box table used by the decrypt datapath.
package aes_pkg;

    localparam int unsigned AES_BYTES  = 16;
    localparam int unsigned BYTE_IDX_W = 4;

    typedef logic [127:0] aes_state_t;

    // Byte view of a state: element [AES_BYTES-1] is byte 0 (MSB, FIPS-197 order).
    typedef logic [AES_BYTES-1:0][7:0] aes_bytes_t;

    // Inverse S-box, indexed by {row, col} = {high nibble, low nibble}.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational inverse S-box lookup for a single byte.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [7:0] inv_sbox_out
);

    assign inv_sbox_out = INV_SBOX[{row, col}];

endmodule

// File: rtl/aes_inv_sub_bytes_unit.sv
// Multi-cycle inverse SubBytes: substitutes LANES bytes per cycle of a captured state in place.
module aes_inv_sub_bytes_unit
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_state,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_state,
    output logic       busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_inv_sub_bytes_unit: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam int unsigned GROUPS = AES_BYTES / LANES;
    // One extra bit so a single-group configuration still has a counter.
    localparam int unsigned CNT_W  = $clog2(GROUPS) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    aes_bytes_t       work_q, work_d;

    logic [BYTE_IDX_W-1:0] lane_pos [LANES];
    logic [7:0]            lane_in  [LANES];
    logic [7:0]            lane_out [LANES];

    // Lane l handles byte cnt*LANES+l, stored at element AES_BYTES-1-index of the byte view.
    for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
        assign lane_pos[l] = BYTE_IDX_W'(AES_BYTES - 1 - (32'(cnt_q) * LANES + 32'(l)));
        assign lane_in[l]  = work_q[lane_pos[l]];

        aes_inv_sbox u_inv_sbox (
            .row          (lane_in[l][7:4]),
            .col          (lane_in[l][3:0]),
            .inv_sbox_out (lane_out[l])
        );
    end

    // State, counter and working register updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
        end
    end

    // Next-state logic: capture in IDLE, substitute one group per BUSY cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = aes_bytes_t'(in_state);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int l = 0; l < int'(LANES); l++) begin
                    work_d[lane_pos[l]] = lane_out[l];
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = aes_state_t'(work_q);

endmodule

// File: tb/tb_aes_inv_sub_bytes_unit.sv
// Directed bench for aes_inv_sub_bytes_unit across LANES = 1, 2, 4, 8, 16 (instance g has LANES = 1 << g).
module tb_aes_inv_sub_bytes_unit;

    localparam int NI  = 5;
    localparam int L4  = 2;
    localparam int MAXW = 40;

    // Ciphertext-side vectors and their hand-derived inverse substitutions.
    localparam logic [127:0] VIN [4] = '{
        128'h637cedb2_b843dda1_63636363_63636363,
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };
    localparam logic [127:0] VEXP [4] = '{
        128'h0001533e_9a64c9f1_00000000_00000000,
        128'h00010203_04050607_08090a0b_0c0d0e0f,
        128'h10111213_14151617_18191a1b_1c1d1e1f,
        128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff
    };

    logic clk = 1'b0;
    logic rst;
    logic [NI-1:0] in_valid;
    logic [NI-1:0] out_ready;
    logic [127:0]  in_state [NI];
    wire  [NI-1:0] in_ready;
    wire  [NI-1:0] out_valid;
    wire  [NI-1:0] busy;
    wire  [127:0]  out_state [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_inv_sub_bytes_unit #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    // Offer one state, then count edges after the accepting edge until out_valid (-1 on timeout).
    task automatic run_txn(input int idx, input logic [127:0] data, output int lat, output logic [127:0] res);
        in_state[idx] = data;
        in_valid[idx] = 1'b1;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        in_state[idx] = '1;
        lat = -1;
        for (int n = 1; n <= MAXW; n++) begin
            @(posedge clk); #1;
            if (out_valid[idx]) begin
                lat = n;
                break;
            end
        end
        res = out_state[idx];
    endtask

    // Hand the result to the consumer for one edge.
    task automatic drain(input int idx);
        out_ready[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 5'b11111) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected %b", in_ready, 5'b11111);
        end
        checks++;
        if (out_valid !== 5'b00000) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected %b", out_valid, 5'b00000);
        end
        checks++;
        if (busy !== 5'b00000) begin
            errors++;
            $display("FAIL reset_busy: got %b expected %b", busy, 5'b00000);
        end
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (out_state[i] !== 128'h0) begin
                errors++;
                $display("FAIL reset_out_state[%0d]: got %h expected 0", i, out_state[i]);
            end
        end
    endtask

    task automatic test_single_byte();
        int lat;
        logic [127:0] res;
        run_txn(L4, VIN[0], lat, res);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL single_latency: got %0d expected 4", lat);
        end
        checks++;
        if (res !== VEXP[0]) begin
            errors++;
            $display("FAIL single_out_state: got %h expected %h", res, VEXP[0]);
        end
        checks++;
        if ({in_ready[L4], busy[L4]} !== 2'b01) begin
            errors++;
            $display("FAIL single_done_flags: got in_ready,busy=%b expected 01", {in_ready[L4], busy[L4]});
        end
        drain(L4);
        checks++;
        if ({in_ready[L4], out_valid[L4], busy[L4]} !== 3'b100) begin
            errors++;
            $display("FAIL single_after_drain: got %b expected 100", {in_ready[L4], out_valid[L4], busy[L4]});
        end
    endtask

    task automatic test_round_trip();
        int lat;
        logic [127:0] res;
        for (int i = 0; i < NI; i++) begin
            run_txn(i, VIN[1 + (i % 3)], lat, res);
            checks++;
            if (lat !== (16 >> i)) begin
                errors++;
                $display("FAIL round_trip_latency lanes=%0d: got %0d expected %0d", 1 << i, lat, 16 >> i);
            end
            checks++;
            if (res !== VEXP[1 + (i % 3)]) begin
                errors++;
                $display("FAIL round_trip_data lanes=%0d: got %h expected %h", 1 << i, res, VEXP[1 + (i % 3)]);
            end
            drain(i);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] res;
        run_txn(L4, VIN[2], lat, res);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL bp_latency: got %0d expected 4", lat);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid[L4] = (c == 3);
            in_state[L4] = VIN[1];
            @(posedge clk); #1;
            checks++;
            if ({out_valid[L4], in_ready[L4]} !== 2'b10 || out_state[L4] !== VEXP[2]) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got valid,ready=%b state=%h expected 10 state=%h",
                         c, {out_valid[L4], in_ready[L4]}, out_state[L4], VEXP[2]);
            end
        end
        in_valid[L4] = 1'b0;
        drain(L4);
        @(posedge clk); #1;
        checks++;
        if ({in_ready[L4], busy[L4], out_valid[L4]} !== 3'b100) begin
            errors++;
            $display("FAIL bp_pulse_ignored: got ready,busy,valid=%b expected 100",
                     {in_ready[L4], busy[L4], out_valid[L4]});
        end
    endtask

    task automatic test_back_to_back();
        int rise [2];
        logic [127:0] got [2];
        int nr = 0;
        logic prev = 1'b0;
        rise[0] = -1;
        rise[1] = -1;
        got[0] = '0;
        got[1] = '0;
        in_state[L4]  = VIN[1];
        in_valid[L4]  = 1'b1;
        out_ready[L4] = 1'b1;
        @(posedge clk); #1;
        in_state[L4] = VIN[2];
        for (int n = 1; n <= MAXW; n++) begin
            @(posedge clk); #1;
            if (out_valid[L4] && !prev) begin
                rise[nr] = n;
                got[nr]  = out_state[L4];
                nr++;
                if (nr == 2) begin
                    in_valid[L4] = 1'b0;
                    break;
                end
            end
            prev = out_valid[L4];
        end
        in_valid[L4] = 1'b0;
        @(posedge clk); #1;
        out_ready[L4] = 1'b0;
        checks++;
        if (nr !== 2) begin
            errors++;
            $display("FAIL b2b_count: got %0d results expected 2", nr);
        end
        checks++;
        if (got[0] !== VEXP[1] || got[1] !== VEXP[2]) begin
            errors++;
            $display("FAIL b2b_data: got %h,%h expected %h,%h", got[0], got[1], VEXP[1], VEXP[2]);
        end
        checks++;
        if (rise[0] !== 4) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d expected 4", rise[0]);
        end
        // Between rises: four BUSY cycles, one DONE cycle, one IDLE cycle.
        checks++;
        if (rise[1] - rise[0] !== 6) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d expected 6", rise[1] - rise[0]);
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        logic [127:0] res;
        logic seen = 1'b0;
        in_state[L4] = VIN[3];
        in_valid[L4] = 1'b1;
        @(posedge clk); #1;
        in_valid[L4] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({out_valid[L4], in_ready[L4], busy[L4]} !== 3'b010) begin
            errors++;
            $display("FAIL midrst_flags: got valid,ready,busy=%b expected 010",
                     {out_valid[L4], in_ready[L4], busy[L4]});
        end
        checks++;
        if (out_state[L4] !== 128'h0) begin
            errors++;
            $display("FAIL midrst_out_state: got %h expected 0", out_state[L4]);
        end
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | out_valid[L4];
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrst_no_result: got out_valid=%b expected 0", seen);
        end
        run_txn(L4, VIN[1], lat, res);
        checks++;
        if (lat !== 4 || res !== VEXP[1]) begin
            errors++;
            $display("FAIL midrst_followup: got lat=%0d state=%h expected lat=4 state=%h", lat, res, VEXP[1]);
        end
        drain(L4);
    endtask

    task automatic test_reset_with_valid();
        logic seen = 1'b0;
        in_state[L4] = VIN[2];
        in_valid[L4] = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid[L4] = 1'b0;
        checks++;
        if ({in_ready[L4], busy[L4]} !== 2'b10) begin
            errors++;
            $display("FAIL rstvalid_flags: got ready,busy=%b expected 10", {in_ready[L4], busy[L4]});
        end
        repeat (5) begin
            @(posedge clk); #1;
            seen = seen | out_valid[L4] | busy[L4];
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstvalid_stays_idle: got activity=%b expected 0", seen);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < NI; i++) in_state[i] = '0;
        test_reset();
        test_single_byte();
        test_round_trip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_reset_with_valid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
